// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit multiplexed seven-segment scanner with an anti-ghost
// blank gap, 16-step PWM brightness and a per-frame snapshot of the segment word.
module sseg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 12500,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          DIG_ACT_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sseg_word,
    input  logic        enable,
    input  logic [3:0]  brightness,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_n,
    output logic        frame_tick
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SLOT_W = SCAN_DIV / 16;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;

    localparam logic [7:0] SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_IDLE = DIG_ACT_LOW ? 4'hF : 4'h0;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dix_q, dix_d;
    logic [31:0]      snap_word_q, snap_word_d;
    logic [3:0]       snap_bri_q, snap_bri_d;
    logic [7:0]       seg_n_q, seg_n_d;
    logic [3:0]       dig_n_q, dig_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic [7:0]       seg_pat;
    logic [3:0]       dig_act;
    logic [3:0]       slot;

    // Next-state logic: scan sequencing, snapshot capture and frame pulse
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dix_d        = dix_q;
        snap_word_d  = snap_word_q;
        snap_bri_d   = snap_bri_q;
        frame_tick_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d     = ST_BLANK;
                    cnt_d       = '0;
                    dix_d       = 2'd0;
                    snap_word_d = sseg_word;
                    snap_bri_d  = brightness;
                end
            end
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ON: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    dix_d   = dix_q + 2'd1;
                    if (dix_q == 2'd3) begin
                        snap_word_d  = sseg_word;
                        snap_bri_d   = brightness;
                        frame_tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Disable overrides everything; re-enable restarts from OFF
        if (!enable) begin
            state_d      = ST_OFF;
            cnt_d        = '0;
            frame_tick_d = 1'b0;
        end
    end

    // Output decode from the next state so outputs line up with the state register
    always_comb begin
        seg_pat = 8'(snap_word_d >> {dix_d, 3'b000});
        dig_act = 4'b0001 << dix_d;
        slot    = 4'(cnt_d / CNT_W'(SLOT_W));
        seg_n_d = SEG_IDLE;
        dig_n_d = DIG_IDLE;
        if (state_d == ST_ON) begin
            dig_n_d = DIG_ACT_LOW ? ~dig_act : dig_act;
            if (slot <= snap_bri_d) begin
                seg_n_d = SEG_ACT_LOW ? ~seg_pat : seg_pat;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            dix_q        <= 2'd0;
            snap_word_q  <= '0;
            snap_bri_q   <= '0;
            seg_n_q      <= SEG_IDLE;
            dig_n_q      <= DIG_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dix_q        <= dix_d;
            snap_word_q  <= snap_word_d;
            snap_bri_q   <= snap_bri_d;
            seg_n_q      <= seg_n_d;
            dig_n_q      <= dig_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dig_n      = dig_n_q;
    assign frame_tick = frame_tick_q;

endmodule
